fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
//
// PURPOSE
//  Instruction buffer between the fetch stage (instruction RAM read) and decode.
//  Decouples fetch from decode stalls: stores {pc, inst} pairs in a circular FIFO.
//  Drains them in order to decode over a valid/ready handshake.
//  A single-cycle flush discards all buffered entries on a PC redirect.
//
// PARAMETERS
//  DEPTH       4   entries; power of two, >= 2
//  PC_WIDTH    64  width of stored pc
//  INST_WIDTH  64  width of stored instruction word
//
// PORTS
//  clk        in   1                     clock; all state updates on rising edge
//  rst        in   1                     synchronous reset, active-high
//  flush      in   1                     discard all entries this cycle (redirect)
//  in_valid   in   1                     fetch presents {in_pc, in_inst}
//  in_ready   out  1                     queue accepts a push this cycle
//  in_pc      in   PC_WIDTH              pc of fetched instruction
//  in_inst    in   INST_WIDTH            fetched instruction word
//  out_valid  out  1                     head entry available to decode
//  out_ready  in   1                     decode consumes head this cycle
//  out_pc     out  PC_WIDTH              pc of head entry
//  out_inst   out  INST_WIDTH            instruction of head entry
//  count      out  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
//
// BEHAVIOUR
//  - Storage: DEPTH-entry array; wr_ptr and rd_ptr, $clog2(DEPTH) bits each.
//    Both pointers wrap modulo DEPTH; occupancy is held in count.
//  - push = in_valid & in_ready & ~flush.
//  - pop = out_valid & out_ready & ~flush.
//  - in_ready = (count != DEPTH). It is a function of registered state only.
//    It never depends on out_ready, so there is no combinational in->out path.
//  - out_valid = (count != 0).
//  - When out_valid=1, out_pc and out_inst show the entry at rd_ptr.
//  - When out_valid=0, out_pc and out_inst are forced to 0.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N.
//    Minimum push-to-pop latency is 1 cycle; there is no same-cycle bypass.
//  - Push and pop in the same cycle:
//    - Both pointers advance; count is unchanged.
//    - Legal at any occupancy except full, where in_ready=0 and only the pop happens.
//  - Full (count=DEPTH):
//    - in_ready=0; in_valid is ignored and no entry is written.
//    - Fetch must hold its data until in_ready rises.
//  - Empty (count=0): out_valid=0; out_ready is ignored.
//  - Flush (priority over push and pop):
//    - Next cycle: wr_ptr=rd_ptr=0, count=0, out_valid=0.
//    - A push offered in the flush cycle is dropped.
//    - in_ready=1 on the cycle after the flush.
//  - Reset: same state as flush. Array contents are not cleared; they are not observable.
//  - Reset wins over flush. Asserting rst mid-stream drops all entries, including one being pushed.
//  - Ordering: entries leave strictly in push order; no duplication or loss except by flush/rst.
//
// TESTING
//  1. Reset, then push pc=0x0,inst=0x13 -> next cycle out_valid=1,
//     out_pc=0x0, out_inst=0x13, count=1.
//  2. out_ready=0, push 4 entries pc=0x0,0x4,0x8,0xC -> count=4, in_ready=0.
//     A 5th push (pc=0x10) is not stored: after 4 pops the 0x10 entry never appears.
//  3. Full queue, in_valid=1 and out_ready=1 together -> only the pop occurs.
//     Next cycle count=3, head pc=0x4, in_ready=1.
//  4. count=2, simultaneous push (pc=0x20) and pop every cycle for 10 cycles ->
//     count stays 2; pcs out in order; pointers wrap with no loss.
//  5. count=3, flush=1 with in_valid=1 (pc=0x40) -> next cycle count=0,
//     out_valid=0, out_pc=0, in_ready=1; 0x40 is never output.
//  6. Random valid/ready for 2000 cycles against a reference queue model ->
//     every popped {pc,inst} matches; count never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : circular {pc, inst} buffer between fetch and decode, with flush
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_WIDTH-1:0]          in_pc,
  input  logic [INST_WIDTH-1:0]        in_inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [INST_WIDTH-1:0]        out_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  push;
  logic                  pop;

  // Handshake flags derive from registered occupancy only: no in->out path.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  assign out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is never cleared; stale slots are hidden by out_valid gating.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_queue : directed and randomized checks of fetch_queue
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 64;
  localparam int IW    = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pc = '0;
  logic [IW-1:0] in_inst = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_inst;
  logic [2:0]    count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .INST_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] inst;
  } entry_t;

  entry_t model_q[$];

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_count", 128'(count), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_pc", 128'(out_pc), 128'd0);

    // Single push visible one cycle later
    in_valid = 1'b1; in_pc = 64'h0; in_inst = 64'h13;
    step();
    in_valid = 1'b0;
    check("t1_out_valid", 128'(out_valid), 128'd1);
    check("t1_out_pc", 128'(out_pc), 128'h0);
    check("t1_out_inst", 128'(out_inst), 128'h13);
    check("t1_count", 128'(count), 128'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_drain_count", 128'(count), 128'd0);

    // Fill to full, then a fifth push is refused
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 64'(i * 4); in_inst = 64'(i * 4 + 'h100);
      step();
    end
    check("t2_full_count", 128'(count), 128'd4);
    check("t2_full_in_ready", 128'(in_ready), 128'd0);
    in_pc = 64'h10; in_inst = 64'h110;
    step();
    check("t2_refused_count", 128'(count), 128'd4);
    check("t2_head_pc", 128'(out_pc), 128'h0);

    // Full with push and pop offered: only the pop happens
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_count", 128'(count), 128'd3);
    check("t3_head_pc", 128'(out_pc), 128'h4);
    check("t3_in_ready", 128'(in_ready), 128'd1);
    for (int i = 1; i < 4; i++) begin
      check("t3_drain_pc", 128'(out_pc), 128'(i * 4));
      check("t3_drain_inst", 128'(out_inst), 128'(i * 4 + 'h100));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("t3_empty_valid", 128'(out_valid), 128'd0);
    check("t3_empty_pc", 128'(out_pc), 128'd0);

    // Steady state at count=2 with concurrent push/pop, pointers wrapping
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 64'(32'h20 + i * 4); in_inst = 64'(32'h200 + i);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      check("t4_head_pc", 128'(out_pc), 128'(32'h20 + k * 4));
      check("t4_head_inst", 128'(out_inst), 128'(32'h200 + k));
      in_valid = 1'b1; out_ready = 1'b1;
      in_pc = 64'(32'h28 + k * 4); in_inst = 64'(32'h202 + k);
      step();
      check("t4_count", 128'(count), 128'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_tail_head_pc", 128'(out_pc), 128'h48);

    // Flush at count=3 with a push offered
    in_valid = 1'b1; in_pc = 64'h50; in_inst = 64'h500;
    step();
    check("t5_pre_count", 128'(count), 128'd3);
    flush = 1'b1; in_pc = 64'h40; in_inst = 64'h400;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_count", 128'(count), 128'd0);
    check("t5_out_valid", 128'(out_valid), 128'd0);
    check("t5_out_pc", 128'(out_pc), 128'd0);
    check("t5_in_ready", 128'(in_ready), 128'd1);
    step();
    check("t5_still_empty", 128'(out_valid), 128'd0);

    // Reset mid-stream drops stored entries and the one being pushed
    in_valid = 1'b1; in_pc = 64'h60; in_inst = 64'h600;
    step();
    rst = 1'b1; in_pc = 64'h64;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_mid_count", 128'(count), 128'd0);
    check("rst_mid_valid", 128'(out_valid), 128'd0);

    // Randomized traffic against a reference queue
    model_q.delete();
    for (int c = 0; c < 2000; c++) begin
      automatic logic   v, r, f, do_push, do_pop;
      automatic entry_t e;
      check("rnd_count", 128'(count), 128'(model_q.size()));
      check("rnd_count_bound", 128'(count <= 3'(DEPTH)), 128'd1);
      check("rnd_out_valid", 128'(out_valid), 128'(model_q.size() != 0));
      if (model_q.size() != 0)
        check("rnd_head", {out_pc, out_inst}, model_q[0]);
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 63) == 0);
      e.pc = {$urandom, $urandom};
      e.inst = {$urandom, $urandom};
      in_valid = v; out_ready = r; flush = f;
      in_pc = e.pc; in_inst = e.inst;
      do_push = v && (model_q.size() < DEPTH) && !f;
      do_pop  = r && (model_q.size() > 0) && !f;
      step();
      if (f) model_q.delete();
      else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
